// File: rtl/hdmi_frame_packer.sv
// Packs a vs/de RGB565 pixel stream into 128-bit words with DDR3 byte addresses,
// buffers them in a first-word-fall-through FIFO and rotates NUM_FRAMES frame buffers.
`timescale 1ns/1ps
module hdmi_frame_packer #(
  parameter int                ADDR_W       = 28,
  parameter logic [ADDR_W-1:0] FRAME_STRIDE = 28'h0400000,
  parameter int                NUM_FRAMES   = 3,
  parameter int                FIFO_DEPTH   = 16
) (
  input  logic                          pix_clk,
  input  logic                          rst,
  input  logic                          vs_in,
  input  logic                          de_in,
  input  logic [15:0]                   rgb565_in,
  input  logic [15:0]                   width_in,
  input  logic [15:0]                   height_in,
  output logic [127:0]                  wr_data,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [1:0]                    wr_frame_idx,
  output logic [1:0]                    rd_frame_idx,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_CLOSE} state_t;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'(NUM_FRAMES - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

  state_t              r_state, w_state_nxt;
  logic                r_vs_d;
  logic [2:0]          r_slot, w_slot_eff;
  logic [127:0]        r_pack, w_pack_nxt, r_flush_data, w_push_data;
  logic                r_pend, r_flush_vld, r_empty, r_partial, r_bad, r_ovf, r_done;
  logic [19:0]         r_word_cnt;
  logic [1:0]          r_wr_idx, r_rd_idx;
  logic [127:0]        r_mem_d [FIFO_DEPTH];
  logic [ADDR_W-1:0]   r_mem_a [FIFO_DEPTH];
  logic [AW-1:0]       r_wptr, r_rptr;
  logic [AW:0]         r_cnt;
  logic                r_wr_valid;
  logic [127:0]        r_wr_data;
  logic [ADDR_W-1:0]   r_wr_addr;

  logic                w_fs, w_start, w_flush_push, w_close, w_done, w_complete;
  logic                w_push, w_full, w_empty, w_pop, w_wr, w_drop;
  logic [ADDR_W-1:0]   w_base, w_push_addr;
  logic [31:0]         w_area, w_target;

  assign w_fs        = vs_in & ~r_vs_d;
  assign w_base      = ADDR_W'(r_wr_idx) * FRAME_STRIDE;
  assign w_push_addr = w_base + ADDR_W'({r_word_cnt, 4'b0000});
  assign w_area      = {16'd0, width_in} * {16'd0, height_in};
  assign w_target    = w_area >> 3;
  // A frame that ended mid-word is short of the expected pixel count.
  assign w_complete  = !r_empty && !r_bad && !r_partial && ({12'd0, r_word_cnt} == w_target);

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_fs) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_CLOSE;
      S_CLOSE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_start      = (r_state == S_IDLE) && w_fs;
    w_flush_push = (r_state == S_FLUSH) && r_flush_vld;
    w_close      = (r_state == S_CLOSE);
    w_done       = w_close && !r_empty;
  end

  // New-frame pixels start at slot 0 from the frame-start cycle onward.
  always_comb begin
    w_slot_eff = w_start ? 3'd0 : r_slot;
    w_pack_nxt = (w_start || r_pend) ? '0 : r_pack;
    if (de_in) w_pack_nxt[16*w_slot_eff +: 16] = rgb565_in;
  end

  assign w_push      = r_pend | w_flush_push;
  assign w_push_data = w_flush_push ? r_flush_data : r_pack;
  assign w_full      = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_empty     = (r_cnt == '0);
  assign w_pop       = !w_empty && (!r_wr_valid || wr_ready);
  assign w_wr        = w_push && (!w_full || w_pop);
  assign w_drop      = w_push && w_full && !w_pop;

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      r_vs_d      <= 1'b0;
      r_slot      <= 3'd0;
      r_pack      <= '0;
      r_pend      <= 1'b0;
      r_flush_vld <= 1'b0;
      r_empty     <= 1'b1;
      r_partial   <= 1'b0;
      r_word_cnt  <= 20'd0;
      r_bad       <= 1'b0;
      r_ovf       <= 1'b0;
      r_done      <= 1'b0;
      r_wr_idx    <= 2'd0;
      r_rd_idx    <= 2'(NUM_FRAMES - 1);
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_wr_valid  <= 1'b0;
      r_wr_data   <= '0;
      r_wr_addr   <= '0;
    end else begin
      // stage p0: edge detect and packing
      r_vs_d <= vs_in;
      r_pack <= w_pack_nxt;
      r_pend <= de_in && (w_slot_eff == 3'd7);
      if (de_in)        r_slot <= w_slot_eff + 3'd1;
      else if (w_start) r_slot <= 3'd0;
      if (w_start) begin
        r_flush_vld <= (r_slot != 3'd0);
        r_partial   <= (r_slot != 3'd0);
        r_empty     <= (r_word_cnt == 20'd0) && (r_slot == 3'd0) && !r_pend;
      end
      // stage p1: push into the FIFO and frame bookkeeping
      if (w_close)     r_word_cnt <= 20'd0;
      else if (w_push) r_word_cnt <= r_word_cnt + 20'd1;
      if (w_close)     r_bad <= 1'b0;
      else if (w_drop) r_bad <= 1'b1;
      if (w_drop)      r_ovf <= 1'b1;
      r_done <= w_done;
      if (w_close && w_complete) begin
        r_rd_idx <= r_wr_idx;
        r_wr_idx <= next_idx(r_wr_idx);
      end
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_wr && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (!w_wr && w_pop) r_cnt <= r_cnt - (AW+1)'(1);
      // stage p2: output register, held while stalled
      if (!r_wr_valid || wr_ready) begin
        r_wr_valid <= !w_empty;
        if (!w_empty) begin
          r_wr_data <= r_mem_d[r_rptr];
          r_wr_addr <= r_mem_a[r_rptr];
        end
      end
    end
  end

  always_ff @(posedge pix_clk) begin
    if (w_start) r_flush_data <= r_pack;
    if (w_wr) begin
      r_mem_d[r_wptr] <= w_push_data;
      r_mem_a[r_wptr] <= w_push_addr;
    end
  end

  assign wr_data      = r_wr_data;
  assign wr_addr      = r_wr_addr;
  assign wr_valid     = r_wr_valid;
  assign wr_frame_idx = r_wr_idx;
  assign rd_frame_idx = r_rd_idx;
  assign frame_done   = r_done;
  assign overflow     = r_ovf;
  assign fifo_level   = r_cnt;

endmodule
